// File: rtl/mem_arbiter.sv
// Two-port (fetch + load/store) arbiter onto a single byte-wide synchronous RAM.
// One transfer at a time, serialised byte by byte, with load/store taking priority over fetch.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_size,
    input  logic              mem_sext,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              if_stall,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] baseAddr_q, baseAddr_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              memSel_q, memSel_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       ifRdata_q, ifRdata_d;
    logic [31:0]       memRdata_q, memRdata_d;
    logic [ADDR_W-1:0] lastAddr_q;

    logic [2:0]        nBytes;
    logic [2:0]        rdOff;
    logic [1:0]        capIdx;
    logic [31:0]       capWord;
    logic [31:0]       loadExt;

    // The read address stops advancing on the last byte while its data comes back.
    always_comb begin
        unique case (size_q)
            2'b00:   nBytes = 3'd1;
            2'b01:   nBytes = 3'd2;
            default: nBytes = 3'd4;
        endcase
        rdOff  = (cnt_q >= nBytes) ? nBytes - 3'd1 : cnt_q;
        capIdx = cnt_q[1:0] - 2'd1;
    end

    always_comb begin
        capWord = rbuf_q;
        capWord[{capIdx, 3'b000} +: 8] = ram_din;
        unique case (size_q)
            2'b00:   loadExt = sext_q ? {{24{capWord[7]}}, capWord[7:0]}
                                      : {24'd0, capWord[7:0]};
            2'b01:   loadExt = sext_q ? {{16{capWord[15]}}, capWord[15:0]}
                                      : {16'd0, capWord[15:0]};
            default: loadExt = capWord;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        baseAddr_d = baseAddr_q;
        size_d     = size_q;
        sext_d     = sext_q;
        wdata_d    = wdata_q;
        memSel_d   = memSel_q;
        rbuf_d     = rbuf_q;
        ifRdata_d  = ifRdata_q;
        memRdata_d = memRdata_q;
        ram_addr   = lastAddr_q;
        ram_wr     = 1'b0;
        ram_dout   = 8'd0;

        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
                    baseAddr_d = mem_addr;
                    size_d     = mem_size;
                    sext_d     = mem_sext;
                    wdata_d    = mem_wdata;
                    memSel_d   = 1'b1;
                    cnt_d      = 3'd0;
                    state_d    = mem_we ? WR : RD;
                end else if (if_req) begin
                    baseAddr_d = if_addr;
                    size_d     = 2'b10;
                    sext_d     = 1'b0;
                    memSel_d   = 1'b0;
                    cnt_d      = 3'd0;
                    state_d    = RD;
                end
            end
            RD: begin
                ram_addr = baseAddr_q + ADDR_W'(rdOff);
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q != 3'd0) begin
                    rbuf_d = capWord;
                end
                if (cnt_q == nBytes) begin
                    state_d = DONE;
                    if (memSel_q) begin
                        memRdata_d = loadExt;
                    end else begin
                        ifRdata_d = capWord;
                    end
                end
            end
            WR: begin
                ram_addr = baseAddr_q + ADDR_W'(cnt_q);
                ram_wr   = 1'b1;
                ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == nBytes - 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            baseAddr_q <= '0;
            size_q     <= 2'b00;
            sext_q     <= 1'b0;
            wdata_q    <= 32'd0;
            memSel_q   <= 1'b0;
            rbuf_q     <= 32'd0;
            ifRdata_q  <= 32'd0;
            memRdata_q <= 32'd0;
            lastAddr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            baseAddr_q <= baseAddr_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            wdata_q    <= wdata_d;
            memSel_q   <= memSel_d;
            rbuf_q     <= rbuf_d;
            ifRdata_q  <= ifRdata_d;
            memRdata_q <= memRdata_d;
            lastAddr_q <= ram_addr;
        end
    end

    assign if_done   = (state_q == DONE) && !memSel_q;
    assign mem_done  = (state_q == DONE) && memSel_q;
    assign if_rdata  = ifRdata_q;
    assign mem_rdata = memRdata_q;
    assign if_stall  = if_req & ~if_done;
    assign mem_stall = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized transfers checked against a
// byte-addressed reference memory and latency/extension rules computed from first principles.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        ifDone;
    logic [31:0] ifRdata;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [1:0]  memSize;
    logic        memSext;
    logic [31:0] memWdata;
    logic        memDone;
    logic [31:0] memRdata;
    logic        ifStall;
    logic        memStall;
    logic [31:0] ramAddr;
    logic        ramWr;
    logic [7:0]  ramDout;
    logic [7:0]  ramDin;

    int compared;
    int mismatched;

    logic [7:0] ramStore [logic [31:0]];
    logic [7:0] refMem   [logic [31:0]];

    logic [31:0] addrLog  [1:21];
    logic        wrLog    [1:21];
    logic [7:0]  doutLog  [1:21];
    logic        stallLog [1:21];

    logic [31:0] latchAddr;
    logic        latchWr;
    logic [7:0]  latchDout;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (ifReq),
        .if_addr   (ifAddr),
        .if_done   (ifDone),
        .if_rdata  (ifRdata),
        .mem_req   (memReq),
        .mem_we    (memWe),
        .mem_addr  (memAddr),
        .mem_size  (memSize),
        .mem_sext  (memSext),
        .mem_wdata (memWdata),
        .mem_done  (memDone),
        .mem_rdata (memRdata),
        .if_stall  (ifStall),
        .mem_stall (memStall),
        .ram_addr  (ramAddr),
        .ram_wr    (ramWr),
        .ram_dout  (ramDout),
        .ram_din   (ramDin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] initByte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] storeRead(input logic [31:0] a);
        return ramStore.exists(a) ? ramStore[a] : initByte(a);
    endfunction

    function automatic logic [7:0] refRead(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initByte(a);
    endfunction

    function automatic int sizeBytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic int expLatency(input logic isMem, input logic we, input logic [1:0] sz);
        int n;
        n = isMem ? sizeBytes(sz) : 4;
        return (isMem && we) ? n + 1 : n + 2;
    endfunction

    function automatic logic [31:0] expLoad(input logic [31:0] a, input logic [1:0] sz, input logic sx);
        int n;
        logic [31:0] w;
        n = sizeBytes(sz);
        w = 32'd0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = refRead(a + 32'(i));
        if (sx && n < 4 && w[8*n-1]) w = w | (32'hFFFFFFFF << (8*n));
        return w;
    endfunction

    task automatic refStore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < sizeBytes(sz); i++) refMem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ramStore[a] = b;
        refMem[a]   = b;
    endtask

    // The RAM captures the previous cycle's request at the edge; sampling at negedge avoids edge races.
    always @(negedge clk) begin
        latchAddr = ramAddr;
        latchWr   = ramWr;
        latchDout = ramDout;
    end

    always @(posedge clk) begin
        ramDin <= storeRead(latchAddr);
        if (latchWr && rst) ramStore[latchAddr] = latchDout;
    end

    task automatic doTransfer(input logic isMem, input logic we, input logic [31:0] a,
                              input logic [1:0] sz, input logic sx, input logic [31:0] wd,
                              output int doneCycle, output int otherDone);
        @(posedge clk); #1;
        if (isMem) begin
            memReq = 1'b1; memWe = we; memAddr = a; memSize = sz; memSext = sx; memWdata = wd;
        end else begin
            ifReq = 1'b1; ifAddr = a;
        end
        @(posedge clk);
        doneCycle = -1;
        otherDone = 0;
        for (int k = 1; k <= 20 && doneCycle < 0; k++) begin
            @(negedge clk);
            addrLog[k]  = ramAddr;
            wrLog[k]    = ramWr;
            doutLog[k]  = ramDout;
            stallLog[k] = isMem ? memStall : ifStall;
            if (isMem ? memDone : ifDone) doneCycle = k;
            if (isMem ? ifDone : memDone) otherDone++;
        end
        memReq = 1'b0;
        ifReq  = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        compared++; if (ramAddr !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_ram_addr: got %h want %h", ramAddr, 32'd0); end
        compared++; if (ramWr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ram_wr: got %b want 0", ramWr); end
        compared++; if (ramDout !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_ram_dout: got %h want 00", ramDout); end
        compared++; if (ifDone !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_if_done: got %b want 0", ifDone); end
        compared++; if (memDone !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_done: got %b want 0", memDone); end
        compared++; if (ifRdata !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_if_rdata: got %h want 0", ifRdata); end
        compared++; if (memRdata !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_mem_rdata: got %h want 0", memRdata); end
        compared++; if (ifStall !== 1'b0 || memStall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %b%b want 00", ifStall, memStall); end
        #14 rst = 1'b1;
    endtask

    task automatic test_fetch;
        int dc, od;
        logic sawWr;
        preload(32'h100, 8'h11); preload(32'h101, 8'h22);
        preload(32'h102, 8'h33); preload(32'h103, 8'h44);
        doTransfer(1'b0, 1'b0, 32'h100, 2'b10, 1'b0, 32'd0, dc, od);
        compared++; if (dc !== 6) begin mismatched++; $display("[TB] FAIL fetch_latency: got %0d want 6", dc); end
        compared++; if (ifRdata !== 32'h44332211) begin mismatched++; $display("[TB] FAIL fetch_data: got %h want 44332211", ifRdata); end
        sawWr = 1'b0;
        for (int k = 1; k <= 6; k++) if (wrLog[k] !== 1'b0) sawWr = 1'b1;
        compared++; if (sawWr !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_no_write: got %b want 0", sawWr); end
        compared++; if (stallLog[1] !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_stall: got %b want 1", stallLog[1]); end
        compared++; if (od !== 0) begin mismatched++; $display("[TB] FAIL fetch_other_done: got %0d want 0", od); end
    endtask

    task automatic test_store_half;
        int dc, od;
        doTransfer(1'b1, 1'b1, 32'h201, 2'b01, 1'b0, 32'h1234BEEF, dc, od);
        refStore(32'h201, 2'b01, 32'h1234BEEF);
        compared++; if (addrLog[1] !== 32'h201 || doutLog[1] !== 8'hEF || wrLog[1] !== 1'b1) begin mismatched++; $display("[TB] FAIL store_cycle1: got %h/%h/%b want 00000201/ef/1", addrLog[1], doutLog[1], wrLog[1]); end
        compared++; if (addrLog[2] !== 32'h202 || doutLog[2] !== 8'hBE || wrLog[2] !== 1'b1) begin mismatched++; $display("[TB] FAIL store_cycle2: got %h/%h/%b want 00000202/be/1", addrLog[2], doutLog[2], wrLog[2]); end
        compared++; if (dc !== 3) begin mismatched++; $display("[TB] FAIL store_latency: got %0d want 3", dc); end
        compared++; if (ramWr !== 1'b0 || ramDout !== 8'd0) begin mismatched++; $display("[TB] FAIL store_done_quiet: got %b/%h want 0/00", ramWr, ramDout); end
        compared++; if (storeRead(32'h201) !== 8'hEF || storeRead(32'h202) !== 8'hBE) begin mismatched++; $display("[TB] FAIL store_ram: got %h %h want ef be", storeRead(32'h201), storeRead(32'h202)); end
        compared++; if (storeRead(32'h203) !== initByte(32'h203)) begin mismatched++; $display("[TB] FAIL store_overrun: got %h want %h", storeRead(32'h203), initByte(32'h203)); end
    endtask

    task automatic test_priority;
        int memDc, ifDc;
        logic [31:0] wd, want;
        wd = $urandom;
        want = expLoad(32'h300, 2'b10, 1'b0);
        @(posedge clk); #1;
        memReq = 1'b1; memWe = 1'b1; memAddr = 32'h400; memSize = 2'b10; memSext = 1'b0; memWdata = wd;
        ifReq = 1'b1; ifAddr = 32'h300;
        @(posedge clk);
        memDc = -1; ifDc = -1;
        for (int k = 1; k <= 25 && ifDc < 0; k++) begin
            @(negedge clk);
            if (memDone) begin memDc = k; memReq = 1'b0; end
            if (ifDone) begin ifDc = k; ifReq = 1'b0; end
        end
        memReq = 1'b0; ifReq = 1'b0;
        refStore(32'h400, 2'b10, wd);
        compared++; if (memDc !== 5) begin mismatched++; $display("[TB] FAIL prio_mem_first: got %0d want 5", memDc); end
        compared++; if (ifDc !== 12) begin mismatched++; $display("[TB] FAIL prio_fetch_after: got %0d want 12", ifDc); end
        compared++; if (ifRdata !== want) begin mismatched++; $display("[TB] FAIL prio_fetch_data: got %h want %h", ifRdata, want); end
    endtask

    task automatic test_load_sext;
        int dc, od;
        preload(32'h500, 8'h80);
        doTransfer(1'b1, 1'b0, 32'h500, 2'b00, 1'b1, 32'd0, dc, od);
        compared++; if (dc !== 3) begin mismatched++; $display("[TB] FAIL load_byte_latency: got %0d want 3", dc); end
        compared++; if (memRdata !== 32'hFFFFFF80) begin mismatched++; $display("[TB] FAIL load_sext: got %h want ffffff80", memRdata); end
        doTransfer(1'b1, 1'b0, 32'h500, 2'b00, 1'b0, 32'd0, dc, od);
        compared++; if (memRdata !== 32'h00000080) begin mismatched++; $display("[TB] FAIL load_zext: got %h want 00000080", memRdata); end
    endtask

    task automatic test_wrap;
        int dc, od;
        logic [31:0] want;
        logic [31:0] wantAddr [1:4];
        wantAddr[1] = 32'hFFFFFFFE; wantAddr[2] = 32'hFFFFFFFF;
        wantAddr[3] = 32'h00000000; wantAddr[4] = 32'h00000001;
        want = expLoad(32'hFFFFFFFE, 2'b10, 1'b0);
        doTransfer(1'b1, 1'b0, 32'hFFFFFFFE, 2'b10, 1'b0, 32'd0, dc, od);
        for (int k = 1; k <= 4; k++) begin
            compared++; if (addrLog[k] !== wantAddr[k]) begin mismatched++; $display("[TB] FAIL wrap_addr%0d: got %h want %h", k, addrLog[k], wantAddr[k]); end
        end
        compared++; if (dc !== 6) begin mismatched++; $display("[TB] FAIL wrap_latency: got %0d want 6", dc); end
        compared++; if (memRdata !== want) begin mismatched++; $display("[TB] FAIL wrap_data: got %h want %h", memRdata, want); end
    endtask

    task automatic test_reset_mid_store;
        int doneSeen;
        @(posedge clk); #1;
        memReq = 1'b1; memWe = 1'b1; memAddr = 32'h600; memSize = 2'b10; memSext = 1'b0; memWdata = 32'hA1B2C3D4;
        @(posedge clk);
        doneSeen = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        compared++; if (ramWr !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_wr: got %b want 0", ramWr); end
        compared++; if (ramAddr !== 32'd0 || ramDout !== 8'd0) begin mismatched++; $display("[TB] FAIL midrst_ram: got %h/%h want 0/0", ramAddr, ramDout); end
        compared++; if (memRdata !== 32'd0) begin mismatched++; $display("[TB] FAIL midrst_rdata: got %h want 0", memRdata); end
        memReq = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (memDone) doneSeen++;
        end
        #2 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (memDone) doneSeen++;
        end
        refMem[32'h600] = 8'hD4;
        compared++; if (doneSeen !== 0) begin mismatched++; $display("[TB] FAIL midrst_no_done: got %0d want 0", doneSeen); end
        compared++; if (storeRead(32'h600) !== 8'hD4) begin mismatched++; $display("[TB] FAIL midrst_byte0: got %h want d4", storeRead(32'h600)); end
        for (int i = 1; i < 4; i++) begin
            compared++; if (storeRead(32'h600 + 32'(i)) !== initByte(32'h600 + 32'(i))) begin mismatched++; $display("[TB] FAIL midrst_byte%0d: got %h want %h", i, storeRead(32'h600 + 32'(i)), initByte(32'h600 + 32'(i))); end
        end
    endtask

    task automatic test_random;
        int dc, od, n;
        logic isMem, we, sx;
        logic [1:0] sz;
        logic [31:0] a, wd, prevIf, prevMem, want;
        for (int t = 0; t < 40; t++) begin
            isMem = ($urandom_range(0, 2) != 0);
            we    = isMem && ($urandom_range(0, 1) == 1);
            sz    = isMem ? 2'($urandom_range(0, 3)) : 2'b10;
            sx    = 1'($urandom_range(0, 1));
            wd    = $urandom;
            a     = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                                : ($urandom & 32'h0000_07FF);
            n     = isMem ? sizeBytes(sz) : 4;
            prevIf  = ifRdata;
            prevMem = memRdata;
            want    = isMem ? expLoad(a, sz, sx) : expLoad(a, 2'b10, 1'b0);
            doTransfer(isMem, we, a, sz, sx, wd, dc, od);
            compared++; if (dc !== expLatency(isMem, we, sz)) begin mismatched++; $display("[TB] FAIL rnd%0d_latency: got %0d want %0d", t, dc, expLatency(isMem, we, sz)); end
            compared++; if (od !== 0) begin mismatched++; $display("[TB] FAIL rnd%0d_other_done: got %0d want 0", t, od); end
            if (we) begin
                refStore(a, sz, wd);
                compared++; if (memRdata !== prevMem || ifRdata !== prevIf) begin mismatched++; $display("[TB] FAIL rnd%0d_store_hold: got %h/%h want %h/%h", t, memRdata, ifRdata, prevMem, prevIf); end
                for (int i = 0; i < n; i++) begin
                    compared++; if (storeRead(a + 32'(i)) !== refRead(a + 32'(i))) begin mismatched++; $display("[TB] FAIL rnd%0d_store_byte%0d: got %h want %h", t, i, storeRead(a + 32'(i)), refRead(a + 32'(i))); end
                end
            end else if (isMem) begin
                compared++; if (memRdata !== want) begin mismatched++; $display("[TB] FAIL rnd%0d_load: got %h want %h (addr %h size %0d sext %b)", t, memRdata, want, a, sz, sx); end
                compared++; if (ifRdata !== prevIf) begin mismatched++; $display("[TB] FAIL rnd%0d_if_hold: got %h want %h", t, ifRdata, prevIf); end
            end else begin
                compared++; if (ifRdata !== want) begin mismatched++; $display("[TB] FAIL rnd%0d_fetch: got %h want %h (addr %h)", t, ifRdata, want, a); end
                compared++; if (memRdata !== prevMem) begin mismatched++; $display("[TB] FAIL rnd%0d_mem_hold: got %h want %h", t, memRdata, prevMem); end
            end
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b0;
        ifReq = 1'b0; ifAddr = 32'd0;
        memReq = 1'b0; memWe = 1'b0; memAddr = 32'd0; memSize = 2'b00; memSext = 1'b0; memWdata = 32'd0;
        ramDin = 8'd0;
        test_reset();
        test_fetch();
        test_store_half();
        test_priority();
        test_load_sext();
        test_wrap();
        test_reset_mid_store();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, default 32, width of all byte addresses.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on posedge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 SHALL have port: if_req  in  1  instruction-fetch request; held high until if_done.
REQ-005 SHALL have port: if_addr  in  ADDR_W  fetch byte address; stable while if_req=1.
REQ-006 SHALL have port: if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-007 SHALL have port: if_rdata  out  32  fetched word, little-endian.
REQ-008 SHALL have port: mem_req  in  1  load/store request; held high until mem_done.
REQ-009 SHALL have port: mem_we  in  1  1=store, 0=load.
REQ-010 SHALL have port: mem_addr  in  ADDR_W  data byte address.
REQ-011 SHALL have port: mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-012 SHALL have port: mem_sext  in  1  load sign-extend enable (byte/half only).
REQ-013 SHALL have port: mem_wdata  in  32  store data; low bytes used.
REQ-014 SHALL have port: mem_done  out  1  one-cycle pulse: access complete.
REQ-015 SHALL have port: mem_rdata  out  32  load result, extended per mem_sext.
REQ-016 SHALL have port: if_stall  out  1  if_req & ~if_done.
REQ-017 SHALL have port: mem_stall  out  1  mem_req & ~mem_done.
REQ-018 SHALL have port: ram_addr  out  ADDR_W  byte-wide RAM address.
REQ-019 SHALL have port: ram_wr  out  1  RAM write strobe.
REQ-020 SHALL have port: ram_dout  out  8  RAM write byte.
REQ-021 SHALL have port: ram_din  in  8  RAM read byte; valid the cycle after ram_addr presented.

Function
REQ-022 SHALL implement states IDLE, RD, WR, DONE; one transfer in flight at a time.
REQ-023 In IDLE, at posedge: mem_req=1 granted (priority over if_req); else if_req=1 granted; grant latches address, size, sext, wdata, requester; cnt=0.
REQ-024 Grant goes to RD for fetches and loads, WR for stores; no preemption once granted.
REQ-025 N = 1/2/4 bytes for size 00/01/10-11; fetch always N=4.
REQ-026 RD: ram_addr=base+min(cnt,N-1), ram_wr=0; each posedge cnt++; at posedge with cnt>=1 capture ram_din into byte cnt-1; posedge capturing byte N-1 -> DONE.
REQ-027 Read latency: done high during cycle N+2 after the granting edge (word: cycle 6, byte: cycle 3).
REQ-028 WR: ram_wr=1, ram_addr=base+cnt, ram_dout=wdata byte cnt (byte 0 first); posedge at cnt=N-1 -> DONE; done high in cycle N+1.
REQ-029 Address arithmetic SHALL be modulo 2^ADDR_W (wrap past all-ones to 0); misaligned addresses allowed.
REQ-030 DONE: exactly one cycle; asserts done of granted requester only; unconditional -> IDLE.
REQ-031 Requests sampled in DONE/RD/WR SHALL be ignored; requester deasserts in done cycle or is re-served.
REQ-032 Load result: byte/half sign-extended when mem_sext=1, zero-extended otherwise; word unchanged; store mem_done leaves mem_rdata unchanged.
REQ-033 if_rdata/mem_rdata SHALL hold last value until next completion for that requester.
REQ-034 In IDLE/DONE: ram_wr=0, ram_dout=0, ram_addr holds last value.

Reset
REQ-035 rst=0 SHALL immediately force IDLE, cnt=0, ram_wr=0, ram_addr=0, ram_dout=0, if_done=mem_done=0, if_rdata=mem_rdata=0, regardless of clk.
REQ-036 Reset mid-transfer SHALL abandon it without done; bytes already written stay written; first grant after rst=1 follows REQ-023.

Verification
REQ-037 Fetch 0x100, RAM 0x100..0x103 = 11,22,33,44 -> if_done in cycle 6, if_rdata=0x44332211, ram_wr never 1.
REQ-038 Store half 0xBEEF @0x201 -> cycle 1: addr 0x201 dout 0xEF wr=1; cycle 2: addr 0x202 dout 0xBE; mem_done cycle 3.
REQ-039 if_req and mem_req rise same edge -> mem served first (mem_done), then fetch granted at next IDLE edge.
REQ-040 Load byte 0x80 with mem_sext=1 -> mem_rdata=0xFFFFFF80; mem_sext=0 -> 0x00000080.
REQ-041 Word read @0xFFFFFFFE -> ram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-042 rst=0 during cycle 2 of word store -> ram_wr=0 immediately, no mem_done, only byte 0 written.
